// File: rtl/axi_pkg.sv
// Shared AXI-side types and constants for the dcache write-back path.
// The entry layout is fixed at the widest line, and narrower LINE_W builds zero-extend into it.
package axi_pkg;

   localparam int WBUF_LINE_W   = 512;
   localparam int LINE_OFF_BITS = 6;
   localparam int LINE_TAG_W    = 32 - LINE_OFF_BITS;

   localparam logic [7:0] AXI_LEN_LINE  = 8'd15;
   localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

   typedef struct packed {
      logic [31:0]            addr;
      logic [WBUF_LINE_W-1:0] data;
      logic [7:0]             len;
      logic [2:0]             size;
      logic [3:0]             strb;
   } wbuf_entry_t;

   function automatic logic [LINE_TAG_W-1:0] line_of(input logic [31:0] a);
      return LINE_TAG_W'(a >> LINE_OFF_BITS);
   endfunction

endpackage

// File: rtl/line_fifo.sv
// In-order entry storage with wrap-around pointers and an occupancy count.
// It exposes every slot's address and validity so that the parent can do the conflict checks.
module line_fifo
   import axi_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        i_push,
   input  wbuf_entry_t i_entry,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output wbuf_entry_t o_head,
   output logic [31:0] o_slot_addr [DEPTH],
   output logic [DEPTH-1:0] o_slot_vld
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wbuf_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   // A refused push cannot be rescued by a pop in the same cycle.
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   always_comb begin
      o_slot_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_slot_addr[i] = r_mem[i].addr;
         o_slot_vld[i]  = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dcache_wbuf.sv
// Write-back buffer between the dcache and the bridge's data-write port.
// It drains entries in order and flags read misses that hit a pending line.
module dcache_wbuf
   import axi_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int LINE_W = WBUF_LINE_W
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [31:0]       wb_addr,
   input  logic [LINE_W-1:0] wb_data,
   input  logic [7:0]        wb_len,
   input  logic [2:0]        wb_size,
   input  logic [3:0]        wb_strb,
   output logic [31:0]       d_waddr,
   output logic [LINE_W-1:0] d_wdata,
   output logic [7:0]        d_wlen,
   output logic [2:0]        d_wsize,
   output logic [3:0]        d_wstrb,
   output logic              d_wvalid,
   input  logic              d_wready,
   input  logic [31:0]       rd_chk_addr,
   output logic              rd_conflict,
   output logic              wb_empty
);

   wbuf_entry_t      w_push;
   wbuf_entry_t      w_head;
   logic             w_full;
   logic             w_empty;
   logic [31:0]      w_slot_addr [DEPTH];
   logic [DEPTH-1:0] w_slot_vld;
   logic [DEPTH-1:0] w_slot_hit;
   logic             w_in_hit;

   assign w_push.addr = wb_addr;
   assign w_push.data = WBUF_LINE_W'(wb_data);
   assign w_push.len  = wb_len;
   assign w_push.size = wb_size;
   assign w_push.strb = wb_strb;

   line_fifo #(.DEPTH(DEPTH)) u_fifo (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .i_push      (wb_valid),
      .i_entry     (w_push),
      .i_pop       (d_wready),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head),
      .o_slot_addr (w_slot_addr),
      .o_slot_vld  (w_slot_vld)
   );

   assign wb_ready = !w_full;
   assign d_wvalid = !w_empty;
   assign wb_empty = w_empty;

   assign d_waddr = w_head.addr;
   assign d_wdata = w_head.data[LINE_W-1:0];
   assign d_wlen  = w_head.len;
   assign d_wsize = w_head.size;
   assign d_wstrb = w_head.strb;

   // The entry being popped this cycle is still valid, so a miss holds until the next cycle.
   always_comb begin
      w_slot_hit = '0;
      for (int i = 0; i < DEPTH; i++)
         w_slot_hit[i] = w_slot_vld[i] &&
            (line_of(w_slot_addr[i]) == line_of(rd_chk_addr));
   end

   assign w_in_hit    = wb_valid && (line_of(wb_addr) == line_of(rd_chk_addr));
   assign rd_conflict = (|w_slot_hit) || w_in_hit;

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed bench for dcache_wbuf that checks every result with an immediate assertion.
module tb_dcache_wbuf;
   import axi_pkg::*;

   localparam int LW = 512;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          wb_valid;
   logic          wb_ready;
   logic [31:0]   wb_addr;
   logic [LW-1:0] wb_data;
   logic [7:0]    wb_len;
   logic [2:0]    wb_size;
   logic [3:0]    wb_strb;
   logic [31:0]   d_waddr;
   logic [LW-1:0] d_wdata;
   logic [7:0]    d_wlen;
   logic [2:0]    d_wsize;
   logic [3:0]    d_wstrb;
   logic          d_wvalid;
   logic          d_wready;
   logic [31:0]   rd_chk_addr;
   logic          rd_conflict;
   logic          wb_empty;

   int checks = 0;
   int errors = 0;
   logic [LW-1:0] pat;

   always #5 aclk = ~aclk;

   dcache_wbuf #(.DEPTH(2), .LINE_W(LW)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_len      (wb_len),
      .wb_size     (wb_size),
      .wb_strb     (wb_strb),
      .d_waddr     (d_waddr),
      .d_wdata     (d_wdata),
      .d_wlen      (d_wlen),
      .d_wsize     (d_wsize),
      .d_wstrb     (d_wstrb),
      .d_wvalid    (d_wvalid),
      .d_wready    (d_wready),
      .rd_chk_addr (rd_chk_addr),
      .rd_conflict (rd_conflict),
      .wb_empty    (wb_empty)
   );

   task automatic chk(input string tag, input logic [LW-1:0] obs,
                      input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_line(input logic [31:0] a);
      wb_addr = a;
      wb_len  = AXI_LEN_LINE;
      wb_size = AXI_SIZE_WORD;
      wb_strb = 4'hf;
      wb_data = {16{a}};
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         pat[i*32 +: 32] = 32'hA500_0000 + i * 32'h0101_0101;
      aresetn = 1'b0;
      wb_valid = 1'b0;
      d_wready = 1'b0;
      rd_chk_addr = 32'h0;
      set_line(32'h0);
      #12;
      chk("rst_wb_ready", wb_ready, 1);
      chk("rst_wb_empty", wb_empty, 1);
      chk("rst_d_wvalid", d_wvalid, 0);
      chk("rst_rd_conflict", rd_conflict, 0);
      chk("rst_d_waddr", d_waddr, 0);
      chk("rst_d_wdata", d_wdata, 0);
      chk("rst_d_wlen", d_wlen, 0);
      chk("rst_d_wstrb", d_wstrb, 0);
      aresetn = 1'b1;
      tick();

      // single line push with late drain
      set_line(32'h1C00_0040);
      wb_data = pat;
      wb_valid = 1'b1;
      #1;
      chk("t1_pre_wvalid", d_wvalid, 0);
      tick();
      wb_valid = 1'b0;
      chk("t1_wvalid", d_wvalid, 1);
      chk("t1_waddr", d_waddr, 32'h1C00_0040);
      chk("t1_wdata", d_wdata, pat);
      chk("t1_wlen", d_wlen, 15);
      chk("t1_wsize", d_wsize, 2);
      chk("t1_wstrb", d_wstrb, 4'hf);
      chk("t1_empty", wb_empty, 0);
      repeat (19) tick();
      chk("t1_hold_waddr", d_waddr, 32'h1C00_0040);
      chk("t1_hold_wdata", d_wdata, pat);
      d_wready = 1'b1;
      tick();
      d_wready = 1'b0;
      chk("t1_pop_wvalid", d_wvalid, 0);
      chk("t1_pop_empty", wb_empty, 1);

      // three lines into two slots
      set_line(32'h100);
      wb_valid = 1'b1;
      tick();
      chk("t2_ready_1", wb_ready, 1);
      set_line(32'h200);
      tick();
      chk("t2_ready_full", wb_ready, 0);
      set_line(32'h300);
      tick();
      chk("t2_stall_ready", wb_ready, 0);
      chk("t2_head0", d_waddr, 32'h100);
      // full: pop and push together, push refused
      d_wready = 1'b1;
      tick();
      d_wready = 1'b0;
      chk("t3_ready_after", wb_ready, 1);
      chk("t3_head1", d_waddr, 32'h200);
      chk("t3_wdata1", d_wdata, {16{32'h200}});
      tick();
      wb_valid = 1'b0;
      chk("t3_accept_full", wb_ready, 0);
      chk("t3_head1_hold", d_waddr, 32'h200);
      d_wready = 1'b1;
      tick();
      chk("t2_head2", d_waddr, 32'h300);
      chk("t2_wvalid2", d_wvalid, 1);
      tick();
      d_wready = 1'b0;
      chk("t2_drained", wb_empty, 1);

      // read-miss conflict
      set_line(32'h0000_1240);
      wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
      rd_chk_addr = 32'h0000_127C;
      #1;
      chk("t4_hit", rd_conflict, 1);
      rd_chk_addr = 32'h0000_1280;
      #1;
      chk("t4_miss", rd_conflict, 0);
      wb_addr = 32'h0000_12B0;
      wb_valid = 1'b1;
      #1;
      chk("t4_in_hit", rd_conflict, 1);
      wb_valid = 1'b0;
      rd_chk_addr = 32'h0000_127C;
      d_wready = 1'b1;
      #1;
      chk("t4_pop_hit", rd_conflict, 1);
      tick();
      d_wready = 1'b0;
      chk("t4_after_pop", rd_conflict, 0);

      // uncached store, then spurious pop
      wb_addr = 32'h8000_0004;
      wb_data = {{(LW-32){1'b0}}, 32'hDEAD_BEEF};
      wb_len = 8'd0;
      wb_size = AXI_SIZE_WORD;
      wb_strb = 4'b0011;
      wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
      chk("t5_waddr", d_waddr, 32'h8000_0004);
      chk("t5_wlen", d_wlen, 0);
      chk("t5_wstrb", d_wstrb, 4'b0011);
      d_wready = 1'b1;
      tick();
      chk("t5_empty", wb_empty, 1);
      tick();
      d_wready = 1'b0;
      chk("t5_spur_empty", wb_empty, 1);
      chk("t5_spur_ready", wb_ready, 1);
      set_line(32'h0000_0A00);
      wb_valid = 1'b1;
      tick();
      set_line(32'h0000_0B00);
      tick();
      wb_valid = 1'b0;
      chk("t5_next_head", d_waddr, 32'h0A00);
      chk("t5_next_full", wb_ready, 0);

      // asynchronous reset with entries queued
      #2;
      aresetn = 1'b0;
      #1;
      chk("t6_rst_empty", wb_empty, 1);
      chk("t6_rst_wvalid", d_wvalid, 0);
      chk("t6_rst_ready", wb_ready, 1);
      chk("t6_rst_waddr", d_waddr, 0);
      #3;
      aresetn = 1'b1;
      set_line(32'h0000_0700);
      wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
      chk("t6_new_head", d_waddr, 32'h0700);
      chk("t6_new_wvalid", d_wvalid, 1);
      d_wready = 1'b1;
      tick();
      d_wready = 1'b0;
      chk("t6_drained", wb_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_wbuf.md
# dcache_wbuf

Write-back buffer between the data cache and the AXI bridge's data-write port. It accepts evicted dirty lines or uncached stores from the dcache in one cycle and lets the dcache continue. It then drains entries in order to the bridge's single outstanding write transaction, and flags read misses that hit a line still waiting in the buffer.

## Interface
- DEPTH, 2: entry count; power of two, ≥2.
- LINE_W, 512: data width per entry.
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low; clock aclk.
- wb_valid  in  1  dcache push request.
- wb_ready  out  1  buffer can accept a push; equals !full.
- wb_addr  in  32  write address.
- wb_data  in  LINE_W  write data, word 0 in bits [31:0].
- wb_len  in  8  AXI beat count minus 1: 15 for a line, 0 for a single store.
- wb_size  in  3  AXI size.
- wb_strb  in  4  byte strobe (single store only; 4'hf for lines).
- d_waddr  out  32  head entry address to the bridge.
- d_wdata  out  LINE_W  head entry data.
- d_wlen  out  8  head entry length.
- d_wsize  out  3  head entry size.
- d_wstrb  out  4  head entry strobe.
- d_wvalid  out  1  head entry present; equals !empty.
- d_wready  in  1  one-cycle pulse from the bridge when the B response completes.
- rd_chk_addr  in  32  dcache read-miss address.
- rd_conflict  out  1  read-miss line matches a pending write.
- wb_empty  out  1  no entries; used by the dcache for fence and uncached-load ordering.

## Operation
- In-order FIFO of entries {addr, data, len, size, strb}.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: count, 0..DEPTH.
- Push: when wb_valid && wb_ready, write the entry at wr_ptr, then wr_ptr++.
- Pop: when d_wready && !empty, rd_ptr++. A d_wready pulse while empty is ignored.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Full: wb_ready=0 and the push is refused, even if a pop happens that cycle. There is no same-cycle bypass.
- Head fields (d_w*) come from the entry at rd_ptr. They stay stable from the time the entry reaches the head until the cycle after its pop. The bridge reads d_waddr and d_wdata throughout the burst, so this stability is mandatory.
- rd_conflict is combinational and equals the OR of the following matches on bits [31:6]:
  - any valid entry's addr matches rd_chk_addr; the entry being popped this cycle still counts;
  - wb_addr matches rd_chk_addr while wb_valid is high.
- While rd_conflict=1, the dcache holds its read miss. The buffer performs no data forwarding.
- Reset mid-operation: all entries are discarded, pointers and count go to 0, and no partial drain resumes. The bridge is reset by the same aresetn.

## Timing
- Reset values:
  - wb_ready=1, wb_empty=1, d_wvalid=0, rd_conflict=0 (absent a wb_valid match);
  - d_waddr, d_wdata, d_wlen, d_wsize, d_wstrb = 0, with storage cleared.
- Push to d_wvalid latency: 1 cycle. d_wvalid rises the edge after the push handshake.
- Pop to next head: the edge that samples d_wready advances rd_ptr. The next entry appears, or d_wvalid falls, in the following cycle, the same cycle the bridge returns to idle.
- wb_ready, d_wvalid and wb_empty are derived from registered count only, with no combinational input paths.
- rd_conflict has a combinational path from rd_chk_addr, wb_valid and wb_addr.
- Sustained throughput is limited by the bridge: one entry per full AW/W/B transaction.

## Structure
- Shared package `axi_pkg`:
  - typedef wbuf_entry_t {addr[31:0], data[LINE_W-1:0], len[7:0], size[2:0], strb[3:0]};
  - LINE_OFF_BITS=6;
  - AXI_LEN_LINE=8'd15;
  - AXI_SIZE_WORD=3'd2.
- One natural sub-module, `line_fifo`: storage plus pointers and count, exposing full, empty and head.
- The conflict comparators live in dcache_wbuf, since they need every entry's address.

## Test plan
- Single push of addr 0x1C00_0040, len 15, data pattern, with d_wready pulsed 20 cycles later: d_wvalid=1 from cycle+1 with fields matching, then d_wvalid=0 and wb_empty=1 one cycle after the pulse.
- Push 3 lines (0x100, 0x200, 0x300) with DEPTH=2:
  - wb_ready=0 after the second push, and the third push is stalled;
  - after the first pop, the third push is accepted;
  - drain order is 0x100, 0x200, 0x300.
- Full buffer with wb_valid and d_wready asserted in the same cycle: the push is refused that cycle, count becomes 1, and the push is accepted the next cycle.
- Entry at 0x0000_1240 pending, rd_chk_addr=0x0000_127C: rd_conflict=1. With rd_chk_addr=0x0000_1280: rd_conflict=0. After the pop: rd_conflict=0.
- Uncached store with addr 0x8000_0004, len 0, strb 4'b0011: d_wlen=0 and d_wstrb=4'b0011. A spurious d_wready pulse while empty leaves the pointers unchanged.
- Assert aresetn low with 2 entries queued: wb_empty=1 and d_wvalid=0 immediately (asynchronous). After release, the first new push appears at the head.
